event_recovery: RTL and testbench
=================================

EVENT_RECOVERY -- requirements
Module: event_recovery

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops (legal 2..4).
REQ-002 SHALL have parameter FILTER_LEN, default 2, consecutive equal synchronized samples needed to accept a level change (legal 1..8; 1 = no filtering).
REQ-003 SHALL have parameter RATE_WIDTH, default clks_alot_p::COUNTER_WIDTH, width of the period counter and rate output.
REQ-004 sys_dom_i  in  common_p::clk_dom_s  single clock domain: .clk rising-edge clock; .rst_n asynchronous active-low reset.
REQ-005 recovery_en_i  in  1  enables edge reporting and period measurement.
REQ-006 clk_src_i  in  1  external clock to recover, asynchronous to sys_dom_i.clk.
REQ-007 recovered_events_o  out  clks_alot_p::recovered_events_s  fields .rise and .fall, one-cycle pulses on accepted edges.
REQ-008 current_rate_o  out  RATE_WIDTH  last measured rise-to-rise period in sys_dom_i.clk cycles.
REQ-009 rate_valid_o  out  1  current_rate_o holds a measurement from the current tracking run.
REQ-010 rate_update_o  out  1  one-cycle pulse when current_rate_o is loaded.
REQ-011 stall_o  out  1  one-cycle pulse when the period counter saturates.

Function
REQ-012 clk_src_i SHALL pass through SYNC_STAGES flops; synchronizer and filter SHALL run regardless of recovery_en_i.
REQ-013 Filtered level SHALL change only after FILTER_LEN consecutive synchronized samples differ from it; any disagreeing sample restarts the run count.
REQ-014 With stable input, .rise/.fall SHALL assert exactly SYNC_STAGES+FILTER_LEN cycles after the first clock edge sampling the new level (defaults: 4).
REQ-015 .rise/.fall SHALL pulse only when the FSM is not IDLE; never both in one cycle.
REQ-016 FSM states: IDLE, ARMED (await first rise), MEASURING (first rise seen, await second), TRACKING.
REQ-017 Any state with recovery_en_i=0 -> IDLE next cycle; IDLE with recovery_en_i=1 -> ARMED.
REQ-018 ARMED + rise -> MEASURING, period counter P <= 0.
REQ-019 MEASURING/TRACKING + rise -> TRACKING, current_rate_o <= sat(P+1), P <= 0, rate_valid_o <= 1, rate_update_o pulses.
REQ-020 Otherwise in MEASURING/TRACKING P SHALL increment by 1 per cycle, saturating at 2^RATE_WIDTH-1.
REQ-021 P reaching 2^RATE_WIDTH-1 without a rise -> ARMED, rate_valid_o <= 0, stall_o pulses once; current_rate_o holds.
REQ-022 Rise on the same cycle P saturates: rise wins, current_rate_o <= 2^RATE_WIDTH-1, no stall_o.
REQ-023 In IDLE and ARMED P SHALL be 0 and rate_valid_o 0; current_rate_o SHALL hold its last value.
REQ-024 Edges filtered out as glitches SHALL NOT affect P or FSM.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 On sys_dom_i.rst_n low, asynchronously: FSM IDLE, P=0, synchronizer and filter level 0, filter run count 0, current_rate_o=0, rate_valid_o=0, all pulses 0.
REQ-027 Reset deassertion with clk_src_i already high SHALL produce a .rise after SYNC_STAGES+FILTER_LEN cycles if enabled.
REQ-028 Reset mid-measurement SHALL discard the partial period; no rate_update_o follows reset.

Verification
REQ-029 Defaults, enable, clk_src_i period 10 cycles (5 high/5 low) -> first rise in ARMED, second rise: current_rate_o=10, rate_valid_o=1, rate_update_o one pulse; every later rise repeats 10.
REQ-030 FILTER_LEN=3, one-cycle and two-cycle high glitches on low clk_src_i -> no .rise, P unaffected; three-cycle high -> .rise at cycle 5 after first high sample.
REQ-031 RATE_WIDTH=8, rise then clk_src_i held low -> stall_o pulses when P=255, state ARMED, rate_valid_o=0, current_rate_o unchanged.
REQ-032 recovery_en_i dropped mid-period for 3 cycles then raised -> no events while IDLE, rate_valid_o=0, next two rises yield correct period only from the second.
REQ-033 Async reset asserted between edges in TRACKING -> all outputs 0 immediately, no rate_update_o until two rises after release.
REQ-034 Rise coincident with P saturation (RATE_WIDTH=8, period 256) -> current_rate_o=255, rate_update_o pulses, stall_o stays 0.

Source files
------------

// File: rtl/event_recovery.sv
// Recovers edges and rise-to-rise period of an asynchronous clock via synchronizer, glitch filter and FSM.
// Latency: edge pulses SYNC_STAGES+FILTER_LEN cycles after the first sampling edge; rate loads with the rise pulse.
// Backpressure: none; free-running pulse outputs, no ready.

package common_p;
    typedef struct packed {
        logic clk;
        logic rst_n;
    } clk_dom_s;
endpackage

package clks_alot_p;
    localparam int COUNTER_WIDTH = 16;

    typedef struct packed {
        logic rise;
        logic fall;
    } recovered_events_s;
endpackage

module event_recovery #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 2,
    parameter int RATE_WIDTH  = clks_alot_p::COUNTER_WIDTH
) (
    input  common_p::clk_dom_s              sys_dom_i,
    input  logic                            recovery_en_i,
    input  logic                            clk_src_i,
    output clks_alot_p::recovered_events_s  recovered_events_o,
    output logic [RATE_WIDTH-1:0]           current_rate_o,
    output logic                            rate_valid_o,
    output logic                            rate_update_o,
    output logic                            stall_o
);

    localparam int                    CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0]      RUN_LAST = CNT_W'(FILTER_LEN - 1);
    localparam logic [RATE_WIDTH-1:0] P_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        MEASURING,
        TRACKING
    } state_t;

    logic clk;
    logic rst_n;
    assign clk   = sys_dom_i.clk;
    assign rst_n = sys_dom_i.rst_n;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic [CNT_W-1:0]       run_q;
    logic                   level_q;
    logic                   level_d_q;
    logic                   rise_acc;
    logic                   fall_acc;
    logic                   report;
    state_t                 state_q;
    logic [RATE_WIDTH-1:0]  period_q;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Synchronizer and filter run even while disabled so a re-enable sees a settled level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            run_q     <= '0;
            level_q   <= 1'b0;
            level_d_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], clk_src_i};
            level_d_q <= level_q;
            if (sync_s == level_q) begin
                run_q <= '0;
            end else if (run_q == RUN_LAST) begin
                level_q <= sync_s;
                run_q   <= '0;
            end else begin
                run_q <= run_q + CNT_W'(1);
            end
        end
    end

    assign rise_acc = level_q & ~level_d_q;
    assign fall_acc = ~level_q & level_d_q;
    assign report   = recovery_en_i && (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= IDLE;
            period_q           <= '0;
            current_rate_o     <= '0;
            rate_valid_o       <= 1'b0;
            rate_update_o      <= 1'b0;
            stall_o            <= 1'b0;
            recovered_events_o <= '0;
        end else begin
            recovered_events_o.rise <= report & rise_acc;
            recovered_events_o.fall <= report & fall_acc;
            rate_update_o           <= 1'b0;
            stall_o                 <= 1'b0;
            if (!recovery_en_i) begin
                state_q      <= IDLE;
                period_q     <= '0;
                rate_valid_o <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: state_q <= ARMED;
                    ARMED: begin
                        if (rise_acc) begin
                            state_q  <= MEASURING;
                            period_q <= '0;
                        end
                    end
                    MEASURING, TRACKING: begin
                        // A rise on the saturating cycle still counts as a measurement.
                        if (rise_acc) begin
                            state_q        <= TRACKING;
                            current_rate_o <= (period_q == P_MAX) ? P_MAX : period_q + RATE_WIDTH'(1);
                            period_q       <= '0;
                            rate_valid_o   <= 1'b1;
                            rate_update_o  <= 1'b1;
                        end else if (period_q == P_MAX) begin
                            state_q      <= ARMED;
                            period_q     <= '0;
                            rate_valid_o <= 1'b0;
                            stall_o      <= 1'b1;
                        end else begin
                            period_q <= period_q + RATE_WIDTH'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_event_recovery.sv
// Scoreboard bench for event_recovery: three instances (defaults, FILTER_LEN=3, RATE_WIDTH=8),
// expected pulses queued at stimulus time and popped by a negedge monitor.
module tb_event_recovery;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_a_n = 1'b0, rst_b_n = 1'b0, rst_c_n = 1'b0;
    logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
    logic src_a = 1'b0, src_b = 1'b0, src_c = 1'b0;

    common_p::clk_dom_s dom_a, dom_b, dom_c;
    assign dom_a = {clk, rst_a_n};
    assign dom_b = {clk, rst_b_n};
    assign dom_c = {clk, rst_c_n};

    clks_alot_p::recovered_events_s ev_a, ev_b, ev_c;
    logic [15:0] rate_a, rate_b;
    logic [7:0]  rate_c;
    logic val_a, val_b, val_c, upd_a, upd_b, upd_c, stall_a, stall_b, stall_c;

    event_recovery dut_a (
        .sys_dom_i(dom_a), .recovery_en_i(en_a), .clk_src_i(src_a),
        .recovered_events_o(ev_a), .current_rate_o(rate_a), .rate_valid_o(val_a),
        .rate_update_o(upd_a), .stall_o(stall_a)
    );

    event_recovery #(.FILTER_LEN(3)) dut_b (
        .sys_dom_i(dom_b), .recovery_en_i(en_b), .clk_src_i(src_b),
        .recovered_events_o(ev_b), .current_rate_o(rate_b), .rate_valid_o(val_b),
        .rate_update_o(upd_b), .stall_o(stall_b)
    );

    event_recovery #(.RATE_WIDTH(8)) dut_c (
        .sys_dom_i(dom_c), .recovery_en_i(en_c), .clk_src_i(src_c),
        .recovered_events_o(ev_c), .current_rate_o(rate_c), .rate_valid_o(val_c),
        .rate_update_o(upd_c), .stall_o(stall_c)
    );

    typedef struct {
        int dut;
        int kind;
        int cyc;
        int val;
    } exp_t;

    exp_t  q[$];
    int    tests = 0;
    int    fails = 0;
    string kname[4] = '{"rise", "fall", "rate_update", "stall"};

    function automatic void push(input int d, input int k, input int c, input int v);
        exp_t e;
        e.dut  = d;
        e.kind = k;
        e.cyc  = c;
        e.val  = v;
        q.push_back(e);
    endfunction

    task automatic pop_cmp(input int d, input int k, input int v);
        exp_t e;
        tests++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_%s: dut=%0d cyc=%0d val=%0d, expected no event", kname[k], d, cyc, v);
        end else begin
            e = q.pop_front();
            if (e.dut != d || e.kind != k || e.cyc != cyc || e.val != v) begin
                fails++;
                $display("FAIL %s: got dut=%0d %s cyc=%0d val=%0d, expected dut=%0d %s cyc=%0d val=%0d",
                         kname[k], d, kname[k], cyc, v, e.dut, kname[e.kind], e.cyc, e.val);
            end
        end
    endtask

    // Update carries the loaded rate (only if valid); stall carries the held rate (only if invalid).
    task automatic mon(input int d, input logic r, input logic f, input logic u, input logic s,
                       input int rate, input logic v);
        if (r) pop_cmp(d, 0, 0);
        if (f) pop_cmp(d, 1, 0);
        if (u) pop_cmp(d, 2, v ? rate : -1);
        if (s) pop_cmp(d, 3, v ? -1 : rate);
    endtask

    always @(negedge clk) begin
        mon(0, ev_a.rise, ev_a.fall, upd_a, stall_a, int'(rate_a), val_a);
        mon(1, ev_b.rise, ev_b.fall, upd_b, stall_b, int'(rate_b), val_b);
        mon(2, ev_c.rise, ev_c.fall, upd_c, stall_c, int'(rate_c), val_c);
    end

    task automatic chk(input string name, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a level change and queue its accepted edge (plus an optional rate update).
    task automatic drive(input int d, input bit v, input int upd);
        int lat;
        lat = (d == 1) ? 5 : 4;
        case (d)
            0:       src_a = v;
            1:       src_b = v;
            default: src_c = v;
        endcase
        push(d, v ? 0 : 1, cyc + 1 + lat, 0);
        if (upd >= 0) push(d, 2, cyc + 1 + lat, upd);
    endtask

    initial begin
        wait_n(2);
        chk("reset_a", {ev_a, val_a, upd_a, stall_a, rate_a}, 0);
        chk("reset_b", {ev_b, val_b, upd_b, stall_b, rate_b}, 0);
        chk("reset_c", {ev_c, val_c, upd_c, stall_c, rate_c}, 0);
        rst_a_n = 1'b1; rst_b_n = 1'b1; rst_c_n = 1'b1;
        en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
        wait_n(3);
        chk("armed_idle_outputs_a", {ev_a, val_a, upd_a, stall_a, rate_a}, 0);
        chk("armed_idle_outputs_c", {ev_c, val_c, upd_c, stall_c, rate_c}, 0);

        // Period 10: first rise only arms the measurement.
        for (int k = 0; k < 4; k++) begin
            drive(0, 1'b1, (k == 0) ? -1 : 10);
            wait_n(5);
            drive(0, 1'b0, -1);
            wait_n(5);
        end
        drive(0, 1'b1, 10);
        wait_n(5);
        chk("valid_tracking_a", val_a, 1);

        // Enable dropped for 3 cycles; the fall accepted during that window is swallowed.
        src_a = 1'b0;
        wait_n(2);
        en_a = 1'b0;
        wait_n(2);
        chk("idle_valid_a", val_a, 0);
        chk("idle_rate_hold_a", rate_a, 10);
        wait_n(1);
        en_a = 1'b1;
        drive(0, 1'b1, -1);
        wait_n(5);
        drive(0, 1'b0, -1);
        wait_n(5);
        drive(0, 1'b1, 10);
        wait_n(7);

        // Asynchronous reset in TRACKING with the source high.
        #2 rst_a_n = 1'b0;
        #1 chk("async_reset_a", {ev_a, val_a, upd_a, stall_a, rate_a}, 0);
        wait_n(2);
        rst_a_n = 1'b1;
        push(0, 0, cyc + 5, 0);
        wait_n(3);
        drive(0, 1'b0, -1);
        wait_n(10);
        drive(0, 1'b1, 13);
        wait_n(5);
        drive(0, 1'b0, -1);
        wait_n(5);
        drive(0, 1'b1, 10);
        wait_n(5);
        drive(0, 1'b0, -1);
        wait_n(8);

        // FILTER_LEN=3: 1- and 2-cycle glitches must not disturb the period count.
        drive(1, 1'b1, -1);
        wait_n(6);
        drive(1, 1'b0, -1);
        wait_n(8);
        src_b = 1'b1;
        wait_n(1);
        src_b = 1'b0;
        wait_n(3);
        src_b = 1'b1;
        wait_n(2);
        src_b = 1'b0;
        wait_n(4);
        drive(1, 1'b1, 24);
        wait_n(3);
        drive(1, 1'b0, -1);
        wait_n(10);

        // RATE_WIDTH=8: stall after a held-low source, then a rise exactly on saturation.
        drive(2, 1'b1, -1);
        wait_n(10);
        drive(2, 1'b0, -1);
        wait_n(10);
        drive(2, 1'b1, 20);
        wait_n(5);
        drive(2, 1'b0, -1);
        push(2, 3, cyc + 256, 20);
        wait_n(275);
        chk("stall_valid_c", val_c, 0);
        chk("stall_rate_hold_c", rate_c, 20);
        drive(2, 1'b1, -1);
        wait_n(10);
        drive(2, 1'b0, -1);
        wait_n(246);
        drive(2, 1'b1, 255);
        wait_n(5);
        chk("sat_valid_c", val_c, 1);
        drive(2, 1'b0, -1);
        wait_n(10);

        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
